// File: rtl/frame_mem_writer.sv
// rtl/frame_mem_writer.sv - packs four pixels per word and writes blocks into frame memory
module frame_mem_writer #(
    parameter int PIX_W     = 8,
    parameter int FRAME_PIX = 76800,
    parameter int ADDR_W    = 17
) (
    input  logic                 GCLK,
    input  logic                 RESETN,
    input  logic [PIX_W-1:0]     pix_data,
    input  logic                 pix_valid,
    input  logic                 pix_sof,
    output logic                 pix_ready,
    output logic                 mem_wr_en,
    output logic [ADDR_W-1:0]    mem_wr_addr,
    output logic [4*PIX_W-1:0]   mem_wr_data,
    input  logic                 mem_wr_ack,
    output logic                 frame_done,
    output logic                 sync_err,
    output logic                 LD0
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 4);

    state_t               state, state_d;
    logic [1:0]           lane, lane_d;
    logic [ADDR_W-1:0]    addr, addr_d;
    logic [4*PIX_W-1:0]   data, data_d;
    logic                 frame_done_d, sync_err_d, ld0, ld0_d;
    logic                 xfer;

    assign pix_ready   = (state != WRITE);
    assign mem_wr_en   = (state == WRITE);
    assign mem_wr_addr = addr;
    assign mem_wr_data = data;
    assign LD0         = ld0;
    assign xfer        = pix_valid && pix_ready;

    always_comb begin
        state_d      = state;
        lane_d       = lane;
        addr_d       = addr;
        data_d       = data;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        ld0_d        = ld0;
        case (state)
            IDLE: begin
                if (xfer && pix_sof) begin
                    data_d  = {pix_data, {(3*PIX_W){1'b0}}};
                    lane_d  = 2'd1;
                    addr_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    // sof anywhere but the very start of a frame restarts the frame at pixel 0
                    if (pix_sof && (lane != 2'd0 || addr != '0)) begin
                        sync_err_d = 1'b1;
                        data_d     = {pix_data, {(3*PIX_W){1'b0}}};
                        lane_d     = 2'd1;
                        addr_d     = '0;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            if (lane == 2'(i)) data_d[(3-i)*PIX_W +: PIX_W] = pix_data;
                        end
                        lane_d = lane + 2'd1;
                        if (lane == 2'd3) state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (mem_wr_ack) begin
                    lane_d = 2'd0;
                    if (addr == LAST_ADDR) begin
                        addr_d       = '0;
                        frame_done_d = 1'b1;
                        ld0_d        = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        addr_d  = addr + ADDR_W'(4);
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge GCLK) begin
        if (!RESETN) begin
            state      <= IDLE;
            lane       <= 2'd0;
            addr       <= '0;
            data       <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            ld0        <= 1'b0;
        end else begin
            state      <= state_d;
            lane       <= lane_d;
            addr       <= addr_d;
            data       <= data_d;
            frame_done <= frame_done_d;
            sync_err   <= sync_err_d;
            ld0        <= ld0_d;
        end
    end

endmodule

// File: tb/tb_frame_mem_writer.sv
// tb/tb_frame_mem_writer.sv - scoreboard bench for frame_mem_writer with a 16-pixel frame
module tb_frame_mem_writer;

    localparam int PIX_W     = 8;
    localparam int FRAME_PIX = 16;
    localparam int ADDR_W    = 5;

    logic                GCLK = 1'b0;
    logic                RESETN = 1'b0;
    logic [PIX_W-1:0]    pix_data = '0;
    logic                pix_valid = 1'b0;
    logic                pix_sof = 1'b0;
    logic                pix_ready;
    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_wr_addr;
    logic [4*PIX_W-1:0]  mem_wr_data;
    logic                mem_wr_ack = 1'b0;
    logic                frame_done;
    logic                sync_err;
    logic                LD0;

    frame_mem_writer #(.PIX_W(PIX_W), .FRAME_PIX(FRAME_PIX), .ADDR_W(ADDR_W)) dut (
        .GCLK(GCLK), .RESETN(RESETN),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(pix_ready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack), .frame_done(frame_done), .sync_err(sync_err), .LD0(LD0)
    );

    always #5 GCLK = ~GCLK;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    int se_cnt = 0;
    logic [ADDR_W+4*PIX_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4*PIX_W-1:0] mk(input logic [7:0] b);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    task automatic push(input int a, input logic [4*PIX_W-1:0] d);
        exp_q.push_back({ADDR_W'(a), d});
    endtask

    // Monitor: every accepted write is checked against the scoreboard head
    initial begin
        logic [ADDR_W+4*PIX_W-1:0] e;
        logic fd_prev, se_prev;
        fd_prev = 1'b0;
        se_prev = 1'b0;
        forever begin
            @(negedge GCLK);
            if (RESETN) begin
                if (mem_wr_en && mem_wr_ack) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                                 mem_wr_addr, mem_wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write", {mem_wr_addr, mem_wr_data}, e);
                    end
                end
                if (frame_done) fd_cnt++;
                if (sync_err) se_cnt++;
                if (frame_done || sync_err) begin
                    chk("pulse_exclusive", 64'(frame_done & sync_err), 64'd0);
                    chk("pulse_width", 64'((frame_done & fd_prev) | (sync_err & se_prev)), 64'd0);
                end
            end
            fd_prev = frame_done;
            se_prev = sync_err;
        end
    end

    task automatic send(input logic [7:0] d, input logic s);
        int n = 0;
        pix_data  = d;
        pix_sof   = s;
        pix_valid = 1'b1;
        while (!pix_ready && n < 50) begin
            @(posedge GCLK); #1;
            n++;
        end
        if (!pix_ready) chk("ready_timeout", 64'd0, 64'd1);
        @(posedge GCLK); #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        repeat (2) @(posedge GCLK);
        #1 RESETN = 1'b1;
    endtask

    task automatic frame(input logic [7:0] base);
        for (int b = 0; b < 4; b++) push(4*b, mk(base + 8'(4*b)));
        for (int i = 0; i < 16; i++) send(base + 8'(i), i == 0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge GCLK); #1;
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge GCLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int fd0, se0;

        // Reset state and one clean frame
        do_reset();
        chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_sync_err", 64'(sync_err), 64'd0);
        chk("rst_ld0", 64'(LD0), 64'd0);
        chk("rst_ready", 64'(pix_ready), 64'd1);
        mem_wr_ack = 1'b1;
        fd0 = fd_cnt; se0 = se_cnt;
        push(0, 32'h00010203);
        push(4, 32'h04050607);
        push(8, 32'h08090A0B);
        push(12, 32'h0C0D0E0F);
        for (int i = 0; i < 16; i++) send(8'(i), i == 0);
        drain("s1_drain");
        chk("s1_frame_done", 64'(fd_cnt - fd0), 64'd1);
        chk("s1_sync_err", 64'(se_cnt - se0), 64'd0);
        chk("s1_ld0", 64'(LD0), 64'd1);
        chk("s1_idle_ready", 64'(pix_ready), 64'd1);

        // Pixels before the first sof are dropped silently
        do_reset();
        fd0 = fd_cnt; se0 = se_cnt;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        repeat (2) @(posedge GCLK);
        #1;
        chk("s2_no_write", 64'(mem_wr_en), 64'd0);
        frame(8'h10);
        drain("s2_drain");
        chk("s2_sync_err", 64'(se_cnt - se0), 64'd0);
        chk("s2_frame_done", 64'(fd_cnt - fd0), 64'd1);

        // Stalled acknowledge holds the write and backpressures the stream
        do_reset();
        mem_wr_ack = 1'b0;
        push(0, 32'h20212223);
        send(8'h20, 1'b1); send(8'h21, 1'b0); send(8'h22, 1'b0); send(8'h23, 1'b0);
        chk("s3_latency", 64'(mem_wr_en), 64'd1);
        repeat (7) begin
            @(negedge GCLK);
            chk("s3_hold_en", 64'(mem_wr_en), 64'd1);
            chk("s3_hold_addr", 64'(mem_wr_addr), 64'd0);
            chk("s3_hold_data", 64'(mem_wr_data), 64'h20212223);
            chk("s3_hold_ready", 64'(pix_ready), 64'd0);
        end
        @(posedge GCLK); #1;
        mem_wr_ack = 1'b1;
        @(posedge GCLK); #1;
        chk("s3_en_drop", 64'(mem_wr_en), 64'd0);
        push(4, 32'h24252627);
        send(8'h24, 1'b0); send(8'h25, 1'b0); send(8'h26, 1'b0); send(8'h27, 1'b0);
        drain("s3_drain");

        // Misaligned sof on the third pixel of the second block
        do_reset();
        se0 = se_cnt;
        push(0, 32'h30313233);
        push(0, 32'h36373839);
        send(8'h30, 1'b1); send(8'h31, 1'b0); send(8'h32, 1'b0); send(8'h33, 1'b0);
        send(8'h34, 1'b0); send(8'h35, 1'b0);
        send(8'h36, 1'b1); send(8'h37, 1'b0); send(8'h38, 1'b0); send(8'h39, 1'b0);
        drain("s4_drain");
        chk("s4_sync_err", 64'(se_cnt - se0), 64'd1);

        // Short frame: sof at a block boundary after 8 pixels
        do_reset();
        fd0 = fd_cnt; se0 = se_cnt;
        push(0, 32'h40414243);
        push(4, 32'h44454647);
        push(0, 32'h48494A4B);
        for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), i == 0);
        send(8'h48, 1'b1); send(8'h49, 1'b0); send(8'h4A, 1'b0); send(8'h4B, 1'b0);
        drain("s5_drain");
        chk("s5_sync_err", 64'(se_cnt - se0), 64'd1);
        chk("s5_frame_done", 64'(fd_cnt - fd0), 64'd0);

        // Reset during a stalled write discards it and clears LD0
        do_reset();
        frame(8'h50);
        drain("s6_frame_drain");
        chk("s6_ld0_set", 64'(LD0), 64'd1);
        mem_wr_ack = 1'b0;
        send(8'h60, 1'b1); send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b0);
        chk("s6_in_write", 64'(mem_wr_en), 64'd1);
        RESETN = 1'b0;
        @(posedge GCLK); #1;
        RESETN = 1'b1;
        chk("s6_rst_en", 64'(mem_wr_en), 64'd0);
        chk("s6_rst_ld0", 64'(LD0), 64'd0);
        mem_wr_ack = 1'b1;
        push(0, 32'h70717273);
        send(8'h70, 1'b1); send(8'h71, 1'b0); send(8'h72, 1'b0); send(8'h73, 1'b0);
        drain("s6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
